// File: rtl/pwm_multichannel_pkg.sv
// Shared types for the multichannel PWM block: counting mode and ramp direction.
package pwm_pkg;

   // Counting shape selected per period: sawtooth or triangle
   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } mode_t;

   // Direction of the shared counter while in center-aligned mode
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Register-write bus used by a local master to program period, mode and duty shadows.
interface pwm_multichannel_if #(
   parameter int N_BIT = 8,
   parameter int N_CH  = 4
);
   import pwm_pkg::*;

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             duty_load;
   logic [CH_W-1:0]  duty_ch;
   logic [N_BIT-1:0] duty_value;
   logic             period_load;
   logic [N_BIT-1:0] period_value;
   mode_t            mode_value;

   // The programming agent drives every field
   modport master (
      output duty_load, duty_ch, duty_value,
      output period_load, period_value, mode_value
   );

   // The PWM block only observes the bus
   modport slave (
      input duty_load, duty_ch, duty_value,
      input period_load, period_value, mode_value
   );

endinterface

// File: rtl/pwm_multichannel_channel.sv
// One PWM output: double-buffered duty threshold plus a compare against the shared count.
module pwm_channel #(
   parameter int N_BIT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dutyWrite,
   input  logic [N_BIT-1:0] dutyValue,
   input  logic             boundary,
   input  logic [N_BIT-1:0] count,
   output logic             pwm
);

   logic [N_BIT-1:0] dutyShadow;
   logic [N_BIT-1:0] dutyActive;

   // The shadow takes software writes at any time, even while the counter is
   // frozen. The active copy only moves at a period boundary so a duty change
   // never produces a truncated or doubled pulse. Because both registers update
   // on the same edge, a write landing in the boundary cycle stays in the shadow
   // and is picked up at the following boundary instead.
   always_ff @(posedge clock) begin
      if (reset) begin
         dutyShadow <= '0;
         dutyActive <= '0;
      end else begin
         if (dutyWrite) begin
            dutyShadow <= dutyValue;
         end
         if (boundary) begin
            dutyActive <= dutyShadow;
         end
      end
   end

   // Output is high whenever the count sits strictly above the threshold, so a
   // threshold of zero is low only at count 0 and one at or above the period
   // never fires.
   always_comb begin
      pwm = (count > dutyActive);
   end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: one shared programmable counter (sawtooth or
// triangle) feeding N_CH comparator channels, with period, mode and duty all
// double-buffered and swapped in together at period boundaries.
module pwm_multichannel #(
   parameter int N_BIT = 8,
   parameter int N_CH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   pwm_multichannel_if.slave bus,
   output logic [N_BIT-1:0]  count,
   output logic [N_CH-1:0]   pwm,
   output logic              period_end
);
   import pwm_pkg::*;

   localparam int               CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [N_BIT-1:0] ONE  = N_BIT'(1);
   localparam logic [N_BIT-1:0] TWO  = N_BIT'(2);

   logic [N_BIT-1:0] countReg;
   logic [N_BIT-1:0] periodShadow;
   logic [N_BIT-1:0] periodActive;
   mode_t            modeShadow;
   mode_t            modeActive;
   dir_t             dir;
   logic             centerMode;
   logic             boundary;

   // A triangle needs at least two steps to have distinct up and down legs, so
   // periods of 0 and 1 fall back to sawtooth behaviour. The sawtooth compare
   // also covers period 0: count is pinned at 0, which always equals the
   // period, so every enabled cycle becomes a boundary.
   always_comb begin
      centerMode = (modeActive == PWM_CENTER) && (periodActive >= TWO);
      if (centerMode) begin
         boundary = enable && (dir == DIR_DOWN) && (countReg == ONE);
      end else begin
         boundary = enable && (countReg == periodActive);
      end
   end

   // Period and mode shadows accept writes regardless of enable; they only
   // reach the counter at the next boundary.
   always_ff @(posedge clock) begin
      if (reset) begin
         periodShadow <= '1;
         modeShadow   <= PWM_EDGE;
      end else if (bus.period_load) begin
         periodShadow <= bus.period_value;
         modeShadow   <= bus.mode_value;
      end
   end

   // Shared counter and its direction. At a boundary everything restarts from
   // zero counting up, and the new period/mode are latched on that same edge.
   // Away from a boundary the sawtooth just increments; the triangle turns
   // around at the top by stepping straight to P-1 so the peak lasts one cycle.
   // The count can never pass the active period, so the increments cannot wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         countReg     <= '0;
         dir          <= DIR_UP;
         periodActive <= '1;
         modeActive   <= PWM_EDGE;
      end else if (enable) begin
         if (boundary) begin
            countReg     <= '0;
            dir          <= DIR_UP;
            periodActive <= periodShadow;
            modeActive   <= modeShadow;
         end else if (!centerMode) begin
            countReg <= countReg + ONE;
         end else if (dir == DIR_UP) begin
            if (countReg == periodActive) begin
               dir      <= DIR_DOWN;
               countReg <= periodActive - ONE;
            end else begin
               countReg <= countReg + ONE;
            end
         end else begin
            countReg <= countReg - ONE;
         end
      end
   end

   // One comparator channel per output, each only listening to writes
   // addressed to its own index; out-of-range indices match nobody.
   for (genvar i = 0; i < N_CH; i++) begin : gChannel
      pwm_channel #(
         .N_BIT (N_BIT)
      ) uChannel (
         .clock     (clock),
         .reset     (reset),
         .dutyWrite (bus.duty_load && (bus.duty_ch == CH_W'(i))),
         .dutyValue (bus.duty_value),
         .boundary  (boundary),
         .count     (countReg),
         .pwm       (pwm[i])
      );
   end

   // Outputs straight from the counter and boundary decode
   always_comb begin
      count      = countReg;
      period_end = boundary;
   end

endmodule
